game_countdown: RTL and testbench
=================================

GAME_COUNTDOWN -- requirements
Module: game_countdown

Interface
REQ-001 Parameter WIDTH, default 6: bit width of the count.
REQ-002 Parameter START_VAL, default 40: value loaded on reset and on start.
REQ-003 Parameter MAX_VAL, default 63: saturation ceiling for bonus additions; legal range START_VAL <= MAX_VAL <= 2^WIDTH-1.
REQ-004 Parameter WARN_THRESH, default 10: low-time warning threshold.
REQ-005 timer_clk, input, 1: sole clock; every register updates on its rising edge.
REQ-006 rst, input, 1: reset, synchronous, active-high.
REQ-007 tick, input, 1: single-cycle count-enable pulse, nominally 1 Hz.
REQ-008 start, input, 1: load START_VAL and begin counting.
REQ-009 pause, input, 1: toggle between running and paused.
REQ-010 add_time, input, 1: bonus request strobe.
REQ-011 add_amount, input, WIDTH: bonus seconds, sampled with add_time.
REQ-012 time_remaining, output, WIDTH: registered current count.
REQ-013 game_end, output, 1: one-cycle pulse on entry to EXPIRED.
REQ-014 expired, output, 1: high while in EXPIRED.
REQ-015 running, output, 1: high while in RUN.
REQ-016 warning, output, 1: high in RUN or PAUSED when 0 < time_remaining <= WARN_THRESH.

Function
REQ-017 The FSM SHALL have four states: IDLE, RUN, PAUSED and EXPIRED; all outputs are registered and have zero added latency relative to the state and count registers.
REQ-018 Priority SHALL be rst > start > pause/tick/add_time.
REQ-019 start in any state SHALL load START_VAL and enter RUN on the next edge, ignoring tick, pause and add_time in that cycle.
REQ-020 In RUN, tick SHALL decrement time_remaining by 1; it is ignored in IDLE, PAUSED and EXPIRED.
REQ-021 A tick in RUN with time_remaining==1 and no effective bonus SHALL set the count to 0, enter EXPIRED and assert game_end for exactly one cycle.
REQ-022 pause SHALL move RUN to PAUSED and PAUSED to RUN; it is ignored in IDLE and EXPIRED.
REQ-023 When tick and pause coincide in RUN, the decrement (and any expiry) SHALL take effect; pause is ignored if the cycle expires, otherwise the state becomes PAUSED.
REQ-024 add_time in RUN or PAUSED SHALL compute the next count as min(time_remaining - (tick in RUN ? 1 : 0) + add_amount, MAX_VAL), evaluated in WIDTH+1 bits with no wrap-around.
REQ-025 A coincident tick and add_time at time_remaining==1 with add_amount>=1 SHALL NOT expire.
REQ-026 add_time with add_amount==0 SHALL behave as if add_time were low; add_time in IDLE or EXPIRED is ignored.
REQ-027 EXPIRED SHALL hold time_remaining at 0 until start or rst; the count never underflows.
REQ-028 game_end SHALL NOT re-assert while the block remains in EXPIRED.

Reset
REQ-029 On rst: state IDLE, time_remaining=START_VAL, game_end=0, expired=0, running=0, warning=0.
REQ-030 rst asserted mid-run or mid-pause SHALL abort the current game with no game_end pulse.

Configuration
REQ-031 Macro GAME_COUNTDOWN_BONUS_EN: when defined, add_time and add_amount behave per REQ-024 to REQ-026.
REQ-032 When GAME_COUNTDOWN_BONUS_EN is undefined, the add_time and add_amount ports SHALL remain present but be ignored; no adder or saturation logic is synthesised.

Verification
REQ-033 Defaults, rst, start, then 40 ticks -> count goes 40 to 0; game_end pulses once on the 40th tick; expired=1; running=0.
REQ-034 start, 5 ticks, pause, 3 ticks, pause, 1 tick -> count=34; running=0 during the pause.
REQ-035 BONUS_EN, count=60 in RUN, add_time with add_amount=10 and a coincident tick -> count=63 (saturated).
REQ-036 count=1 in RUN, tick with add_time and add_amount=5 -> count=5, no game_end; without BONUS_EN -> count=0 and game_end pulses.
REQ-037 count=10 in RUN -> warning=1; count=11 -> warning=0; EXPIRED -> warning=0; rst at count=25 in PAUSED -> IDLE, count=40.
REQ-038 In EXPIRED, drive ticks, pause and add_time, then start -> count stays 0 with no extra game_end; after start, count=40 and running=1.

Source files
------------

// File: rtl/game_countdown.sv
// Game countdown timer: counts down from START_VAL on each tick while running,
// supports pause/resume, flags a low-time warning and pulses game_end on expiry.
// Optional bonus-time feature is enabled by defining GAME_COUNTDOWN_BONUS_EN;
// without it add_time/add_amount are present but ignored.
module game_countdown #(
    parameter int WIDTH       = 6,
    parameter int START_VAL   = 40,
    parameter int MAX_VAL     = 63,
    parameter int WARN_THRESH = 10
) (
    input  logic             timer_clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             start,
    input  logic             pause,
    input  logic             add_time,
    input  logic [WIDTH-1:0] add_amount,
    output logic [WIDTH-1:0] time_remaining,
    output logic             game_end,
    output logic             expired,
    output logic             running,
    output logic             warning
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] START_W = WIDTH'(START_VAL);
    localparam logic [WIDTH-1:0] WARN_W  = WIDTH'(WARN_THRESH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             game_end_q, game_end_d;
    logic             expired_q, expired_d;
    logic             running_q, running_d;
    logic             warning_q, warning_d;

    // A bonus is only effective with a non-zero amount; bonusCount is the
    // count that results when a bonus is applied this cycle.
    logic             bonusValid;
    logic [WIDTH-1:0] bonusCount;

`ifdef GAME_COUNTDOWN_BONUS_EN
    localparam logic [WIDTH-1:0] MAX_W  = WIDTH'(MAX_VAL);
    localparam logic [WIDTH:0]   MAX_W1 = (WIDTH+1)'(MAX_VAL);

    logic             tickDec;
    logic [WIDTH:0]   bonusSum;

    assign bonusValid = add_time && (add_amount != '0);
    assign tickDec    = (state_q == RUN) && tick;

    // Bonus sum in one extra bit so it can never wrap, then clamp to MAX_VAL.
    always_comb begin
        bonusSum   = {1'b0, count_q} + {1'b0, add_amount} - {{WIDTH{1'b0}}, tickDec};
        bonusCount = (bonusSum > MAX_W1) ? MAX_W : bonusSum[WIDTH-1:0];
    end
`else
    logic unusedBonusInputs;

    assign bonusValid        = 1'b0;
    assign bonusCount        = count_q;
    assign unusedBonusInputs = ^{add_time, add_amount};
`endif

    // Next-state and next-count logic; start overrides everything but reset.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (start) begin
            state_d = RUN;
            count_d = START_W;
        end else begin
            case (state_q)
                RUN: begin
                    if (bonusValid) begin
                        count_d = bonusCount;
                        if (pause) state_d = PAUSED;
                    end else if (tick) begin
                        if (count_q <= WIDTH'(1)) begin
                            count_d = '0;
                            state_d = EXPIRED;
                        end else begin
                            count_d = count_q - WIDTH'(1);
                            if (pause) state_d = PAUSED;
                        end
                    end else if (pause) begin
                        state_d = PAUSED;
                    end
                end
                PAUSED: begin
                    if (bonusValid) count_d = bonusCount;
                    if (pause) state_d = RUN;
                end
                EXPIRED: begin
                    count_d = '0;
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs are derived from the next state/count so they register alongside them.
    always_comb begin
        game_end_d = (state_q == RUN) && (state_d == EXPIRED);
        expired_d  = (state_d == EXPIRED);
        running_d  = (state_d == RUN);
        warning_d  = ((state_d == RUN) || (state_d == PAUSED)) &&
                     (count_d != '0) && (count_d <= WARN_W);
    end

    // State, count and output registers with synchronous reset.
    always_ff @(posedge timer_clk) begin
        if (rst) begin
            state_q    <= IDLE;
            count_q    <= START_W;
            game_end_q <= 1'b0;
            expired_q  <= 1'b0;
            running_q  <= 1'b0;
            warning_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            game_end_q <= game_end_d;
            expired_q  <= expired_d;
            running_q  <= running_d;
            warning_q  <= warning_d;
        end
    end

    assign time_remaining = count_q;
    assign game_end       = game_end_q;
    assign expired        = expired_q;
    assign running        = running_q;
    assign warning        = warning_q;

endmodule

// File: tb/tb_game_countdown.sv
// Directed testbench for game_countdown with default parameters.
module tb_game_countdown;

    logic       timer_clk = 1'b0;
    logic       rst       = 1'b1;
    logic       tick      = 1'b0;
    logic       start     = 1'b0;
    logic       pause     = 1'b0;
    logic       add_time  = 1'b0;
    logic [5:0] add_amount = 6'd0;
    logic [5:0] time_remaining;
    logic       game_end;
    logic       expired;
    logic       running;
    logic       warning;

    int errors = 0;
    int checks = 0;

    game_countdown dut (
        .timer_clk      (timer_clk),
        .rst            (rst),
        .tick           (tick),
        .start          (start),
        .pause          (pause),
        .add_time       (add_time),
        .add_amount     (add_amount),
        .time_remaining (time_remaining),
        .game_end       (game_end),
        .expired        (expired),
        .running        (running),
        .warning        (warning)
    );

    // Free-running 10-time-unit clock.
    always #5 timer_clk = ~timer_clk;

    // Drive one cycle of inputs, let the edge pass, then sample 1 unit later.
    task automatic applyStimulus(input logic t, input logic s, input logic p,
                                 input logic a, input logic [5:0] amt);
        tick       = t;
        start      = s;
        pause      = p;
        add_time   = a;
        add_amount = amt;
        @(posedge timer_clk);
        #1;
        tick       = 1'b0;
        start      = 1'b0;
        pause      = 1'b0;
        add_time   = 1'b0;
        add_amount = 6'd0;
    endtask

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    initial begin
        $display("[TB] game_countdown directed test starting");

        // Reset held, start must lose against reset.
        applyStimulus(0, 0, 0, 0, 6'd0);
        applyStimulus(0, 1, 0, 0, 6'd0);
        checkOutput("rst_count", int'(time_remaining), 40);
        checkOutput("rst_running", int'(running), 0);
        checkOutput("rst_expired", int'(expired), 0);
        checkOutput("rst_game_end", int'(game_end), 0);
        checkOutput("rst_warning", int'(warning), 0);
        rst = 1'b0;

        // Tick and pause ignored in IDLE.
        applyStimulus(1, 0, 0, 0, 6'd0);
        checkOutput("idle_tick_count", int'(time_remaining), 40);
        applyStimulus(0, 0, 1, 0, 6'd0);
        checkOutput("idle_pause_running", int'(running), 0);

        // Start wins over coincident tick/pause.
        applyStimulus(1, 1, 1, 0, 6'd0);
        checkOutput("start_count", int'(time_remaining), 40);
        checkOutput("start_running", int'(running), 1);

        // Full countdown 40 -> 1, warning exactly at 10 and below.
        for (int k = 1; k <= 39; k++) begin
            applyStimulus(1, 0, 0, 0, 6'd0);
            checkOutput("countdown", int'(time_remaining), 40 - k);
            checkOutput("countdown_game_end", int'(game_end), 0);
            checkOutput("countdown_warning", int'(warning), ((40 - k) <= 10) ? 1 : 0);
        end
        applyStimulus(1, 0, 0, 0, 6'd0);
        checkOutput("expire_count", int'(time_remaining), 0);
        checkOutput("expire_game_end", int'(game_end), 1);
        checkOutput("expire_expired", int'(expired), 1);
        checkOutput("expire_running", int'(running), 0);
        checkOutput("expire_warning", int'(warning), 0);
        applyStimulus(0, 0, 0, 0, 6'd0);
        checkOutput("expire_pulse_end", int'(game_end), 0);
        checkOutput("expire_hold", int'(expired), 1);

        // Tick, pause and add_time all ignored in EXPIRED.
        applyStimulus(1, 0, 0, 0, 6'd0);
        checkOutput("exp_tick_count", int'(time_remaining), 0);
        checkOutput("exp_tick_game_end", int'(game_end), 0);
        applyStimulus(0, 0, 1, 0, 6'd0);
        checkOutput("exp_pause_running", int'(running), 0);
        checkOutput("exp_pause_expired", int'(expired), 1);
        applyStimulus(0, 0, 0, 1, 6'd5);
        checkOutput("exp_add_count", int'(time_remaining), 0);
        checkOutput("exp_add_game_end", int'(game_end), 0);
        applyStimulus(0, 1, 0, 0, 6'd0);
        checkOutput("restart_count", int'(time_remaining), 40);
        checkOutput("restart_running", int'(running), 1);
        checkOutput("restart_expired", int'(expired), 0);

        // Pause sequence: 5 ticks, pause, 3 ignored ticks, resume, 1 tick.
        for (int k = 0; k < 5; k++) applyStimulus(1, 0, 0, 0, 6'd0);
        checkOutput("pre_pause_count", int'(time_remaining), 35);
        applyStimulus(0, 0, 1, 0, 6'd0);
        checkOutput("paused_running", int'(running), 0);
        for (int k = 0; k < 3; k++) applyStimulus(1, 0, 0, 0, 6'd0);
        checkOutput("paused_count", int'(time_remaining), 35);
        checkOutput("paused_running2", int'(running), 0);
        applyStimulus(0, 0, 1, 0, 6'd0);
        checkOutput("resume_running", int'(running), 1);
        applyStimulus(1, 0, 0, 0, 6'd0);
        checkOutput("resume_tick_count", int'(time_remaining), 34);

        // Coincident tick and pause: decrement then pause.
        applyStimulus(1, 0, 1, 0, 6'd0);
        checkOutput("tick_pause_count", int'(time_remaining), 33);
        checkOutput("tick_pause_running", int'(running), 0);
        applyStimulus(0, 0, 1, 0, 6'd0);
        for (int k = 0; k < 8; k++) applyStimulus(1, 0, 0, 0, 6'd0);
        applyStimulus(0, 0, 1, 0, 6'd0);
        checkOutput("pause25_count", int'(time_remaining), 25);
        checkOutput("pause25_running", int'(running), 0);

        // Reset while paused aborts the game without game_end.
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 6'd0);
        checkOutput("abort_count", int'(time_remaining), 40);
        checkOutput("abort_running", int'(running), 0);
        checkOutput("abort_game_end", int'(game_end), 0);
        checkOutput("abort_expired", int'(expired), 0);
        rst = 1'b0;
        applyStimulus(0, 0, 1, 0, 6'd0);
        checkOutput("abort_idle_pause", int'(running), 0);

        // Count down to 1, then tick with a coincident bonus.
        applyStimulus(0, 1, 0, 0, 6'd0);
        for (int k = 0; k < 39; k++) applyStimulus(1, 0, 0, 0, 6'd0);
        checkOutput("at_one_count", int'(time_remaining), 1);
        checkOutput("at_one_warning", int'(warning), 1);
        applyStimulus(1, 0, 0, 1, 6'd5);
`ifdef GAME_COUNTDOWN_BONUS_EN
        checkOutput("bonus_rescue_count", int'(time_remaining), 5);
        checkOutput("bonus_rescue_game_end", int'(game_end), 0);
        checkOutput("bonus_rescue_running", int'(running), 1);
`else
        checkOutput("nobonus_expire_count", int'(time_remaining), 0);
        checkOutput("nobonus_expire_game_end", int'(game_end), 1);
        checkOutput("nobonus_expire_expired", int'(expired), 1);
`endif

        // Bonus arithmetic and saturation (or absence of it).
        applyStimulus(0, 1, 0, 1, 6'd20);
        checkOutput("start_add_count", int'(time_remaining), 40);
        applyStimulus(0, 0, 0, 1, 6'd20);
`ifdef GAME_COUNTDOWN_BONUS_EN
        checkOutput("add20_count", int'(time_remaining), 60);
        applyStimulus(1, 0, 0, 1, 6'd10);
        checkOutput("add_sat_count", int'(time_remaining), 63);
        applyStimulus(1, 0, 0, 1, 6'd0);
        checkOutput("add_zero_count", int'(time_remaining), 62);
        applyStimulus(0, 0, 1, 0, 6'd0);
        applyStimulus(1, 0, 0, 1, 6'd5);
        checkOutput("paused_add_count", int'(time_remaining), 63);
`else
        checkOutput("add20_ignored", int'(time_remaining), 40);
        applyStimulus(1, 0, 0, 1, 6'd10);
        checkOutput("add_tick_count", int'(time_remaining), 39);
        applyStimulus(1, 0, 0, 1, 6'd0);
        checkOutput("add_zero_count", int'(time_remaining), 38);
        applyStimulus(0, 0, 1, 0, 6'd0);
        applyStimulus(1, 0, 0, 1, 6'd5);
        checkOutput("paused_add_count", int'(time_remaining), 38);
`endif
        checkOutput("paused_add_running", int'(running), 0);

        // Expiry with coincident pause: expiry wins.
        applyStimulus(0, 1, 0, 0, 6'd0);
        for (int k = 0; k < 39; k++) applyStimulus(1, 0, 0, 0, 6'd0);
        applyStimulus(1, 0, 1, 0, 6'd0);
        checkOutput("pause_expire_count", int'(time_remaining), 0);
        checkOutput("pause_expire_game_end", int'(game_end), 1);
        checkOutput("pause_expire_expired", int'(expired), 1);
        checkOutput("pause_expire_running", int'(running), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
